// File: rtl/adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_pkg: shared types, flag bit positions and configuration check for
// pipelined_adder.  Rev 1.0
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic bit stages_valid(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_segment.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_segment: one SEG-bit combinational add slice with carry in/out.
// Rev 1.0
// ---------------------------------------------------------------------------
module adder_segment
  import adder_pkg::*;
#(
  parameter int SEG = 32
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_adder: WIDTH-bit add/sub split into STAGES registered carry
// segments with valid/ready handshakes; macro ADDER_FLAGS_EN builds NZCV. Rev 1.0
// ---------------------------------------------------------------------------
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int SEG = WIDTH / STAGES;

  if (!stages_valid(WIDTH, STAGES)) begin : g_cfg_check
    $fatal(1, "pipelined_adder: STAGES must be 1..WIDTH and divide WIDTH");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;

  // The whole pipe advances or holds as one; no bubble squeezing.
  assign w_en     = out_ready | ~out_valid;
  assign in_ready = w_en;
  assign w_b_eff  = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * SEG;
    localparam int DONE = LO + SEG;
    localparam int IW   = WIDTH - LO;

    logic [IW-1:0]   w_a_in;
    logic [IW-1:0]   w_b_in;
    logic            w_cin;
    logic            w_valid_in;
    logic [SEG-1:0]  w_seg_sum;
    logic            w_seg_cout;
    logic [DONE-1:0] w_sum_next;
    logic            r_valid;
    logic [DONE-1:0] r_sum;

    if (k == 0) begin : g_head
      assign w_a_in     = a;
      assign w_b_in     = w_b_eff;
      assign w_cin      = sub;
      assign w_valid_in = in_valid;
      assign w_sum_next = w_seg_sum;
    end else begin : g_tail
      assign w_a_in     = g_stage[k-1].g_mid.r_a;
      assign w_b_in     = g_stage[k-1].g_mid.r_b;
      assign w_cin      = g_stage[k-1].g_mid.r_carry;
      assign w_valid_in = g_stage[k-1].r_valid;
      assign w_sum_next = {w_seg_sum, g_stage[k-1].r_sum};
    end

    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a    (w_a_in[SEG-1:0]),
      .b    (w_b_in[SEG-1:0]),
      .cin  (w_cin),
      .sum  (w_seg_sum),
      .cout (w_seg_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_sum   <= '0;
      end else if (w_en) begin
        r_valid <= w_valid_in;
        r_sum   <= w_sum_next;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      localparam int REM = WIDTH - DONE;
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;
      logic           r_carry;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_a     <= '0;
          r_b     <= '0;
          r_carry <= 1'b0;
        end else if (w_en) begin
          r_a     <= w_a_in[IW-1:SEG];
          r_b     <= w_b_in[IW-1:SEG];
          r_carry <= w_seg_cout;
        end
      end
    end else begin : g_last
`ifdef ADDER_FLAGS_EN
      logic r_carry;
      logic r_a_msb;
      logic r_b_msb;

      // Operand sign bits are captured here for the overflow flag.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_carry <= 1'b0;
          r_a_msb <= 1'b0;
          r_b_msb <= 1'b0;
        end else if (w_en) begin
          r_carry <= w_seg_cout;
          r_a_msb <= w_a_in[IW-1];
          r_b_msb <= w_b_in[IW-1];
        end
      end
`else
      logic w_carry_unused;
      assign w_carry_unused = w_seg_cout;
`endif
    end
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign out       = g_stage[STAGES-1].r_sum;

`ifdef ADDER_FLAGS_EN
  flags_t w_flags;
  logic   w_a_msb;
  logic   w_b_msb;

  assign w_a_msb = g_stage[STAGES-1].g_last.r_a_msb;
  assign w_b_msb = g_stage[STAGES-1].g_last.r_b_msb;

  // Flags read as zero whenever no result is presented.
  always_comb begin
    w_flags = '0;
    if (out_valid) begin
      w_flags.n = out[WIDTH-1];
      w_flags.z = (out == '0);
      w_flags.c = g_stage[STAGES-1].g_last.r_carry;
      w_flags.v = (w_a_msb == w_b_msb) & (out[WIDTH-1] != w_a_msb);
    end
  end

  assign flags = w_flags;
`else
  assign flags = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipelined_adder: randomized and directed checks of pipelined_adder
// against a transaction-level arithmetic model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int W = 64;
  parameter int STAGES = 2;

`ifdef ADDER_FLAGS_EN
  localparam logic [3:0] FLAG_MASK = 4'hF;
`else
  localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [3:0]   flags;

  pipelined_adder #(
    .WIDTH  (W),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           adv0;
    int           acc_cyc;
  } exp_t;

  exp_t         sb[$];
  int           adv;
  int           cyc;
  int           n_checks;
  int           n_fail;
  bit           lat_chk;
  bit           use_lit;
  logic [W-1:0] lit_res;
  logic [3:0]   lit_flg;
  bit           took;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Plain signed/unsigned arithmetic, independent of the segment structure.
  function automatic void ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic s, output logic [W-1:0] r,
                                    output logic [3:0] f);
    logic signed [W+1:0] sx, sy, sr;
    logic [W:0]          usum;
    sx   = $signed({{2{x[W-1]}}, x});
    sy   = $signed({{2{y[W-1]}}, y});
    sr   = s ? (sx - sy) : (sx + sy);
    usum = {1'b0, x} + {1'b0, y};
    r    = s ? (x - y) : (x + y);
    f    = 4'h0;
    f[FLAG_N] = r[W-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = s ? (x >= y) : usum[W];
    f[FLAG_V] = (sr[W] != sr[W-1]);
    f = f & FLAG_MASK;
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 7))
      0:       return {W{1'b0}};
      1:       return {W{1'b1}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One clock cycle: entered just after a falling edge with inputs driven.
  task automatic step(output bit acc);
    exp_t e;
    bit   mov;
    bit   men;
    #1;
    mov = (sb.size() > 0) && ((adv - sb[0].adv0) >= STAGES);
    check("out_valid", W'(out_valid), W'(mov));
    if (mov) begin
      check("out", out, sb[0].res);
      check("flags", W'(flags), W'(sb[0].flg));
    end
    men = out_ready | ~mov;
    check("in_ready", W'(in_ready), W'(men));
    if (mov && out_ready) begin
      if (lat_chk) check("latency", W'(cyc - sb[0].acc_cyc), W'(STAGES));
      void'(sb.pop_front());
    end
    acc = in_valid && men;
    if (acc) begin
      e.adv0    = adv;
      e.acc_cyc = cyc;
      if (use_lit) begin
        e.res = lit_res;
        e.flg = lit_flg & FLAG_MASK;
      end else begin
        ref_model(a, b, sub, e.res, e.flg);
      end
      sb.push_back(e);
    end
    if (men) adv++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [W-1:0] r, input logic [3:0] f);
    in_valid = 1'b1; a = x; b = y; sub = s;
    use_lit = 1'b1; lit_res = r; lit_flg = f;
    step(took);
    in_valid = 1'b0; use_lit = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) step(took);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < STAGES + 40 && sb.size() > 0; i++) step(took);
    check("drain_empty", W'(sb.size()), W'(0));
  endtask

  initial begin
    n_checks = 0; n_fail = 0; adv = 0; cyc = 0;
    lat_chk = 1'b0; use_lit = 1'b0; lit_res = '0; lit_flg = '0; took = 1'b0;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out", out, '0);
    check("rst_flags", W'(flags), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors with literal expected results.
    lat_chk = 1'b1;
    directed(64'h1234567890ABCDEF, 64'hFEDCBA0987654321, 1'b0, 64'h1111108218111110, 4'b0010);
    directed(64'h5, 64'h5, 1'b1, 64'h0, 4'b0110);
    directed(64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h0, 4'b0110);
    directed(64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h8000000000000000, 4'b1001);

    // Back-to-back stream, then a stall with the pipe full, then release.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = rnd(); b = rnd(); sub = 1'($urandom_range(0, 1));
      step(took);
    end
    lat_chk = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (took) begin a = rnd(); b = rnd(); sub = 1'($urandom_range(0, 1)); end
      step(took);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (took) begin a = rnd(); b = rnd(); sub = 1'($urandom_range(0, 1)); end
      step(took);
    end
    drain();

    // Reset with two ops in flight.
    lat_chk = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = rnd(); b = rnd(); sub = 1'($urandom_range(0, 1));
      step(took);
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_rst_out_valid", W'(out_valid), W'(0));
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < STAGES + 2; i++) step(took);
    directed(64'h0000000100000001, 64'hFFFFFFFF00000000, 1'b0, 64'h0000000000000001, 4'b0010);

    // Randomized traffic with random back-pressure.
    lat_chk = 1'b0;
    took = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 9) < 7);
        a = rnd(); b = rnd(); sub = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step(took);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
